// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_engine
// Purpose  : Tick-driven LED pattern generator (shift / bounce / blink / hold)
//            with registered monochrome and RGB channel outputs.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_engine #(
    parameter int NB_LEDS = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_tick,
    input  logic [1:0]         i_mode,
    input  logic               i_dir,
    input  logic [1:0]         i_color,
    output logic [NB_LEDS-1:0] o_led,
    output logic [NB_LEDS-1:0] o_led_r,
    output logic [NB_LEDS-1:0] o_led_g,
    output logic [NB_LEDS-1:0] o_led_b,
    output logic               o_wrap
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_shift  = 3'd1;
    localparam logic [2:0] c_st_bounce = 3'd2;
    localparam logic [2:0] c_st_blink  = 3'd3;
    localparam logic [2:0] c_st_hold   = 3'd4;

    localparam logic [NB_LEDS-1:0] c_one  = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_LEDS-1:0] c_ones = {NB_LEDS{1'b1}};
    localparam logic [NB_LEDS-1:0] c_zero = {NB_LEDS{1'b0}};

    logic [2:0]         r_state;
    logic [NB_LEDS-1:0] r_pattern;
    logic               r_bdir;       // 0: moving toward MSB, 1: toward LSB
    logic [1:0]         r_prev_mode;
    logic [NB_LEDS-1:0] r_led;
    logic [NB_LEDS-1:0] r_led_r;
    logic [NB_LEDS-1:0] r_led_g;
    logic [NB_LEDS-1:0] r_led_b;
    logic               r_wrap;

    logic [2:0]         w_state_nx;
    logic [2:0]         w_mode_state;
    logic [NB_LEDS-1:0] w_pat_nx;
    logic               w_bdir_nx;
    logic               w_wrap_nx;
    logic               w_switch;
    logic [NB_LEDS-1:0] w_led_nx;
    logic               w_sel_r;
    logic               w_sel_g;
    logic               w_sel_b;

    always_comb begin
        w_mode_state = c_st_shift;
        case (i_mode)
            2'b00:   w_mode_state = c_st_shift;
            2'b01:   w_mode_state = c_st_bounce;
            2'b10:   w_mode_state = c_st_blink;
            default: w_mode_state = c_st_hold;
        endcase
    end

    // Leaving IDLE and changing mode both reload the pattern; a tick in that
    // same cycle is deliberately dropped.
    assign w_switch = (r_state == c_st_idle) || (i_mode != r_prev_mode);

    always_comb begin
        w_state_nx = r_state;
        w_pat_nx   = r_pattern;
        w_bdir_nx  = r_bdir;
        w_wrap_nx  = 1'b0;
        if (!i_enable) begin
            w_state_nx = c_st_idle;
        end else if (w_switch) begin
            w_state_nx = w_mode_state;
            case (i_mode)
                2'b00: w_pat_nx = c_one;
                2'b01: begin
                    w_pat_nx  = c_one;
                    w_bdir_nx = 1'b0;
                end
                2'b10:   w_pat_nx = c_ones;
                default: w_pat_nx = r_pattern;
            endcase
        end else if (i_tick) begin
            case (r_state)
                c_st_shift: begin
                    if (!i_dir) begin
                        w_pat_nx  = {r_pattern[NB_LEDS-2:0], r_pattern[NB_LEDS-1]};
                        w_wrap_nx = r_pattern[NB_LEDS-1];
                    end else begin
                        w_pat_nx  = {r_pattern[0], r_pattern[NB_LEDS-1:1]};
                        w_wrap_nx = r_pattern[0];
                    end
                end
                c_st_bounce: begin
                    if (!r_bdir) begin
                        if (r_pattern[NB_LEDS-1]) begin
                            w_pat_nx  = r_pattern >> 1;
                            w_bdir_nx = 1'b1;
                            w_wrap_nx = (NB_LEDS == 2);
                        end else begin
                            w_pat_nx = r_pattern << 1;
                        end
                    end else begin
                        if (r_pattern[0]) begin
                            w_pat_nx  = r_pattern << 1;
                            w_bdir_nx = 1'b0;
                        end else begin
                            w_pat_nx  = r_pattern >> 1;
                            w_wrap_nx = r_pattern[1];
                        end
                    end
                end
                c_st_blink: begin
                    w_pat_nx  = (r_pattern == c_zero) ? c_ones : c_zero;
                    w_wrap_nx = (r_pattern == c_zero);
                end
                default: begin
                    w_pat_nx = r_pattern;
                end
            endcase
        end
    end

    assign w_led_nx = (w_state_nx == c_st_idle) ? c_zero : w_pat_nx;
    assign w_sel_r  = (i_color == 2'b00) || (i_color == 2'b11);
    assign w_sel_g  = (i_color == 2'b01) || (i_color == 2'b11);
    assign w_sel_b  = (i_color == 2'b10) || (i_color == 2'b11);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= c_st_idle;
            r_pattern   <= c_one;
            r_bdir      <= 1'b0;
            r_prev_mode <= 2'b00;
            r_led       <= c_zero;
            r_led_r     <= c_zero;
            r_led_g     <= c_zero;
            r_led_b     <= c_zero;
            r_wrap      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pattern   <= w_pat_nx;
            r_bdir      <= w_bdir_nx;
            r_prev_mode <= i_mode;
            r_led       <= w_led_nx;
            r_led_r     <= w_sel_r ? w_led_nx : c_zero;
            r_led_g     <= w_sel_g ? w_led_nx : c_zero;
            r_led_b     <= w_sel_b ? w_led_nx : c_zero;
            r_wrap      <= w_wrap_nx && (w_state_nx != c_st_idle);
        end
    end

    assign o_led   = r_led;
    assign o_led_r = r_led_r;
    assign o_led_g = r_led_g;
    assign o_led_b = r_led_b;
    assign o_wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_engine
// Purpose  : Directed self-checking bench for led_pattern_engine (NB_LEDS=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_engine;

    localparam int NB_LEDS = 4;

    logic               clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_enable = 1'b0;
    logic               i_tick = 1'b0;
    logic [1:0]         i_mode = 2'b00;
    logic               i_dir = 1'b0;
    logic [1:0]         i_color = 2'b00;
    logic [NB_LEDS-1:0] o_led;
    logic [NB_LEDS-1:0] o_led_r;
    logic [NB_LEDS-1:0] o_led_g;
    logic [NB_LEDS-1:0] o_led_b;
    logic               o_wrap;

    int n_checks = 0;
    int n_fails  = 0;

    led_pattern_engine #(.NB_LEDS(NB_LEDS)) u_dut (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_enable (i_enable),
        .i_tick   (i_tick),
        .i_mode   (i_mode),
        .i_dir    (i_dir),
        .i_color  (i_color),
        .o_led    (o_led),
        .o_led_r  (o_led_r),
        .o_led_g  (o_led_g),
        .o_led_b  (o_led_b),
        .o_wrap   (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic rst, input logic en, input logic tick,
                        input logic [1:0] mode, input logic dir, input logic [1:0] color);
        i_rst    = rst;
        i_enable = en;
        i_tick   = tick;
        i_mode   = mode;
        i_dir    = dir;
        i_color  = color;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] led, input logic wrap,
                           input logic [1:0] color);
        logic [3:0] er;
        logic [3:0] eg;
        logic [3:0] eb;
        er = (color == 2'b00 || color == 2'b11) ? led : 4'b0000;
        eg = (color == 2'b01 || color == 2'b11) ? led : 4'b0000;
        eb = (color == 2'b10 || color == 2'b11) ? led : 4'b0000;
        check({tag, ".led"},  32'(o_led),   32'(led));
        check({tag, ".wrap"}, 32'(o_wrap),  32'(wrap));
        check({tag, ".r"},    32'(o_led_r), 32'(er));
        check({tag, ".g"},    32'(o_led_g), 32'(eg));
        check({tag, ".b"},    32'(o_led_b), 32'(eb));
    endtask

    logic [3:0] shift_exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       shift_wrap [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] bnc_exp    [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic       bnc_wrap   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] blk_exp    [4] = '{4'b0000, 4'b1111, 4'b0000, 4'b1111};
    logic       blk_wrap   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset, with enable/tick asserted to confirm reset dominates
        step(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b11);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        chk_out("reset", 4'b0000, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        chk_out("idle", 4'b0000, 1'b0, 2'b00);

        // SHIFT toward MSB; tick on the IDLE-exit cycle is dropped
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        chk_out("shift.load", 4'b0001, 1'b0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
            chk_out($sformatf("shift.t%0d", k), shift_exp[k], shift_wrap[k], 2'b00);
        end
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        chk_out("shift.notick", 4'b0001, 1'b0, 2'b00);

        // SHIFT toward LSB wraps bit0 -> MSB
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
        chk_out("shiftr.wrap", 4'b1000, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 2'b00);
        chk_out("shiftr.t1", 4'b0100, 1'b0, 2'b00);

        // Mode switch in the same cycle as a tick: tick dropped, reload
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        chk_out("bounce.load", 4'b0001, 1'b0, 2'b00);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
            chk_out($sformatf("bounce.t%0d", k), bnc_exp[k], bnc_wrap[k], 2'b00);
        end

        // BLINK on all colours
        step(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b11);
        chk_out("blink.load", 4'b1111, 1'b0, 2'b11);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'b11);
            chk_out($sformatf("blink.t%0d", k), blk_exp[k], blk_wrap[k], 2'b11);
        end
        // Colour change without a tick leaves the pattern alone
        step(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b01);
        chk_out("color.green", 4'b1111, 1'b0, 2'b01);

        // SHIFT to 1000, then HOLD freezes it
        step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b10);
        chk_out("shift2.load", 4'b0001, 1'b0, 2'b10);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b10);
            chk_out($sformatf("shift2.t%0d", k), shift_exp[k], 1'b0, 2'b10);
        end
        step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b10);
        chk_out("hold.enter", 4'b1000, 1'b0, 2'b10);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b10);
            chk_out($sformatf("hold.t%0d", k), 4'b1000, 1'b0, 2'b10);
        end
        step(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b10);
        chk_out("hold.disable", 4'b0000, 1'b0, 2'b10);

        // Reset mid-BOUNCE discards progress
        step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00);
        chk_out("bounce2.load", 4'b0001, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        chk_out("bounce2.t1", 4'b0100, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        chk_out("bounce2.rst", 4'b0000, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        chk_out("bounce2.restart", 4'b0001, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        chk_out("bounce2.r1", 4'b0010, 1'b0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 SHALL have parameter NB_LEDS, default 4, number of LEDs driven; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port i_enable, input, 1, run enable; 0 forces IDLE.
REQ-005 SHALL have port i_tick, input, 1, one-cycle step pulse from the upstream period counter's o_valid.
REQ-006 SHALL have port i_mode, input, 2, pattern select: 00 SHIFT, 01 BOUNCE, 10 BLINK, 11 HOLD.
REQ-007 SHALL have port i_dir, input, 1, SHIFT direction: 0 toward MSB, 1 toward LSB.
REQ-008 SHALL have port i_color, input, 2, colour select: 00 red, 01 green, 10 blue, 11 white (all three).
REQ-009 SHALL have port o_led, output, NB_LEDS, registered monochrome pattern.
REQ-010 SHALL have ports o_led_r, o_led_g, o_led_b, output, NB_LEDS each, registered RGB channel patterns.
REQ-011 SHALL have port o_wrap, output, 1, one-cycle pulse marking pattern cycle boundary.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, BOUNCE, BLINK, HOLD; state is registered.
REQ-013 SHALL go to IDLE on the cycle after i_enable=0, from any state; IDLE drives all pattern outputs to 0.
REQ-014 SHALL leave IDLE when i_enable=1, entering the state selected by i_mode on the next cycle.
REQ-015 SHALL treat a change in i_mode (vs. registered previous mode) while enabled as a mode switch: new state next cycle, pattern reloaded.
REQ-016 SHALL use reload values: SHIFT/BOUNCE 0...01, BOUNCE direction toward MSB, BLINK all-ones; HOLD keeps current pattern.
REQ-017 SHALL ignore i_tick in any cycle where a mode switch or IDLE exit occurs (switch wins).
REQ-018 SHALL advance the pattern only on cycles with i_tick=1; outputs reflect the step one cycle later (latency 1).
REQ-019 SHIFT SHALL rotate one-hot by one position per tick per i_dir; i_dir is sampled at each tick, no reload on change.
REQ-020 SHIFT SHALL wrap MSB->bit0 (dir 0) and bit0->MSB (dir 1); o_wrap pulses in the cycle the wrapped pattern appears.
REQ-021 BOUNCE SHALL move one-hot one position per tick, reversing at bit NB_LEDS-1 and bit0 without repeating the end position.
REQ-022 BOUNCE SHALL pulse o_wrap in the cycle the pattern reaches bit0 after a reversal at MSB.
REQ-023 BLINK SHALL toggle between all-ones and all-zeros per tick; o_wrap pulses on each zeros->ones transition.
REQ-024 HOLD SHALL freeze the pattern and ignore i_tick; o_wrap stays 0.
REQ-025 o_wrap SHALL be 0 in every cycle not named in REQ-020/022/023; never high for two consecutive cycles unless two ticks are consecutive.
REQ-026 o_led_r/g/b SHALL equal o_led on selected channel(s) and 0 otherwise, registered with o_led (same cycle alignment).
REQ-027 i_color changes SHALL take effect on the next cycle regardless of i_tick, without altering the pattern.
REQ-028 Output registers SHALL be the only drivers of all outputs (no combinational paths from inputs).

Reset
REQ-029 On i_rst=1 at a clock edge, state SHALL become IDLE, pattern 0...01, bounce dir toward MSB, previous-mode reg 00.
REQ-030 During and after reset, o_led, o_led_r, o_led_g, o_led_b, o_wrap SHALL be 0 until the first non-IDLE cycle.
REQ-031 Reset SHALL override enable, tick and mode in the same cycle; asserting reset mid-pattern SHALL discard progress.

Verification (NB_LEDS=4)
REQ-032 Reset then enable, mode 00, dir 0, color 00, 5 ticks -> o_led 0001,0010,0100,1000,0001; o_wrap on the 5th; o_led_r=o_led, g=b=0.
REQ-033 Mode 01, 7 ticks -> 0010,0100,1000,0100,0010,0001,0010; o_wrap exactly once, with 0001.
REQ-034 Mode 10, 4 ticks -> 0000,1111,0000,1111; o_wrap on ticks 2 and 4; color 11 -> r=g=b=o_led.
REQ-035 SHIFT at 0100, mode switched to 01 in same cycle as tick -> tick dropped, pattern 0001 next cycle, no o_wrap.
REQ-036 SHIFT at 1000, mode 11, 3 ticks -> 1000 held, o_wrap 0; i_enable=0 -> all outputs 0 next cycle.
REQ-037 i_rst asserted mid-BOUNCE at 0100 with tick -> all outputs 0 next cycle; re-enable mode 01 restarts from 0001.
